leiwand_rv32_wb_timer: RTL and testbench

- Wishbone responder peripheral for the leiwand_rv32 SoC: 64-bit machine timer (mtime/mtimecmp), timer interrupt, 2-bit LED output register.
- Sits on the CPU core's data bus beside the internal RAM. The top level gates wb_stb with its address-window decode, so this block decodes only wb_addr[4:2].
- Same single-outstanding, stall/ack handshake as the RAM, so the core needs no changes.

---
 rtl/leiwand_rv32_wb_timer_if.sv | 27 ++
 rtl/leiwand_rv32_wb_timer.sv | 191 +++++++++++++++++++
 tb/tb_leiwand_rv32_wb_timer.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/leiwand_rv32_wb_timer_if.sv
// Wishbone responder bundle for leiwand_rv32_wb_timer.
// Signals: addr/data in/out, we, stb, cyc, ack, stall, write size.
interface leiwand_rv32_wb_timer_if #(
  parameter int MEM_WIDTH = 32
);
  logic [MEM_WIDTH-1:0] wb_addr;
  logic [MEM_WIDTH-1:0] wb_data_in;
  logic [MEM_WIDTH-1:0] wb_data_out;
  logic                 wb_we;
  logic                 wb_stb;
  logic                 wb_ack;
  logic                 wb_cyc;
  logic                 wb_stall;
  logic [2:0]           data_write_size;

  modport master (
    output wb_addr, wb_data_in, wb_we,
    output wb_stb, wb_cyc, data_write_size,
    input  wb_data_out, wb_ack, wb_stall
  );

  modport slave (
    input  wb_addr, wb_data_in, wb_we,
    input  wb_stb, wb_cyc, data_write_size,
    output wb_data_out, wb_ack, wb_stall
  );
endinterface

// File: rtl/leiwand_rv32_wb_timer.sv
// Wishbone timer: 64-bit mtime/mtimecmp, timer irq, 2-bit LED reg.
// Ports: clk, reset (sync, high), bus (wb slave), timer_irq, led.
module leiwand_rv32_wb_timer #(
  parameter int MEM_WIDTH      = 32,
  parameter int PRESCALE       = 8,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  leiwand_rv32_wb_timer_if.slave bus,
  output logic                   timer_irq,
  output logic [1:0]             led
);

  typedef enum logic {
    S_IDLE,
    S_ACK
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_ack;
  logic   w_stall;

  logic [1:0]                r_led;
  logic [63:0]               r_mtime;
  logic [63:0]               r_mtimecmp;
  logic                      r_count_en;
  logic                      r_irq_en;
  logic                      r_pending;
  logic                      r_irq;
  logic [PRESCALE_WIDTH-1:0] r_presc;
  logic [31:0]               r_shadow_hi;
  logic [MEM_WIDTH-1:0]      r_rdata;

  logic                 w_acc;
  logic                 w_wr;
  logic                 w_sz_ok;
  logic                 w_tick;
  logic [2:0]           w_sel;
  logic [MEM_WIDTH-1:0] w_rdata;
  logic [MEM_WIDTH-1:0] w_old;
  logic [MEM_WIDTH-1:0] w_new;
  logic                 w_unused;

  // Overlay the addressed lane(s) of d onto the current word.
  function automatic logic [31:0] f_merge(
    input logic [31:0] old,
    input logic [31:0] d,
    input logic [1:0]  a,
    input logic [2:0]  sz
  );
    logic [31:0] m;
    m = old;
    case (sz)
      3'd4: m = d;
      3'd2: m[16*a[1] +: 16] = d[15:0];
      3'd1: m[8*a +: 8] = d[7:0];
      default: m = old;
    endcase
    return m;
  endfunction

  assign w_sel   = bus.wb_addr[4:2];
  assign w_acc   = (r_state == S_IDLE) &
                   bus.wb_cyc & bus.wb_stb;
  assign w_sz_ok = (bus.data_write_size == 3'd1) |
                   (bus.data_write_size == 3'd2) |
                   (bus.data_write_size == 3'd4);
  assign w_wr    = w_acc & bus.wb_we & w_sz_ok;
  assign w_tick  = r_count_en &&
    (r_presc == PRESCALE_WIDTH'(PRESCALE - 1));

  // w_rdata: what a read returns; w_old: base for merging a write.
  always_comb begin
    w_rdata = '0;
    w_old   = '0;
    case (w_sel)
      3'd0: begin
        w_rdata = {30'b0, r_led};
        w_old   = {30'b0, r_led};
      end
      3'd1: begin
        w_rdata = r_mtime[31:0];
        w_old   = r_mtime[31:0];
      end
      3'd2: begin
        w_rdata = r_shadow_hi;
        w_old   = r_mtime[63:32];
      end
      3'd3: begin
        w_rdata = r_mtimecmp[31:0];
        w_old   = r_mtimecmp[31:0];
      end
      3'd4: begin
        w_rdata = r_mtimecmp[63:32];
        w_old   = r_mtimecmp[63:32];
      end
      3'd5: begin
        w_rdata = {29'b0, r_pending, r_irq_en, r_count_en};
        w_old   = {29'b0, r_pending, r_irq_en, r_count_en};
      end
      default: begin
        w_rdata = '0;
        w_old   = '0;
      end
    endcase
  end

  assign w_new = f_merge(w_old, bus.wb_data_in,
                         bus.wb_addr[1:0],
                         bus.data_write_size);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ack       = 1'b0;
    w_stall     = 1'b0;
    case (r_state)
      S_IDLE: if (w_acc) w_state_nxt = S_ACK;
      S_ACK: begin
        w_ack       = 1'b1;
        w_stall     = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led       <= '0;
      r_mtime     <= '0;
      r_mtimecmp  <= '1;
      r_count_en  <= 1'b0;
      r_irq_en    <= 1'b0;
      r_pending   <= 1'b0;
      r_irq       <= 1'b0;
      r_presc     <= '0;
      r_shadow_hi <= '0;
      r_rdata     <= '0;
    end else begin
      if (w_acc && !bus.wb_we) begin
        r_rdata <= w_rdata;
        // LO read snapshots HI so a LO/HI pair is coherent.
        if (w_sel == 3'd1) r_shadow_hi <= r_mtime[63:32];
      end
      if (r_count_en) begin
        r_presc <= w_tick ? '0 :
          r_presc + PRESCALE_WIDTH'(1);
      end
      if (w_tick) r_mtime <= r_mtime + 64'd1;
      // Bus writes to mtime override the tick, no carry.
      if (w_wr) begin
        case (w_sel)
          3'd0: r_led <= w_new[1:0];
          3'd1: begin
            r_mtime <= {r_mtime[63:32], w_new};
            r_presc <= '0;
          end
          3'd2: begin
            r_mtime <= {w_new, r_mtime[31:0]};
            r_presc <= '0;
          end
          3'd3: r_mtimecmp[31:0]  <= w_new;
          3'd4: r_mtimecmp[63:32] <= w_new;
          3'd5: begin
            r_count_en <= w_new[0];
            r_irq_en   <= w_new[1];
          end
          default: ;
        endcase
      end
      r_pending <= (r_mtime >= r_mtimecmp);
      r_irq     <= r_pending & r_irq_en;
    end
  end

  assign bus.wb_ack      = w_ack;
  assign bus.wb_stall    = w_stall;
  assign bus.wb_data_out = r_rdata;
  assign timer_irq       = r_irq;
  assign led             = r_led;

  assign w_unused = ^bus.wb_addr[MEM_WIDTH-1:5];

endmodule

// File: tb/tb_leiwand_rv32_wb_timer.sv
// Bench for leiwand_rv32_wb_timer: arithmetic model + random bus.
// mtime modelled as base + enabled_cycles / PRESCALE.
module tb_leiwand_rv32_wb_timer;

  localparam int P = 8;

  logic       clk;
  logic       reset;
  logic       timer_irq;
  logic [1:0] led;

  leiwand_rv32_wb_timer_if #(.MEM_WIDTH(32)) bus ();

  leiwand_rv32_wb_timer #(
    .MEM_WIDTH(32),
    .PRESCALE(P),
    .PRESCALE_WIDTH(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .timer_irq(timer_irq),
    .led(led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_busy;
  logic [31:0] m_rdata;
  logic [1:0]  m_led;
  logic [63:0] m_base;
  logic [63:0] m_cyc;
  logic [63:0] m_cmp;
  logic [31:0] m_shadow;
  logic        m_cen, m_ien, m_pend, m_irq;

  logic [63:0] m_now;
  logic        m_acc;
  logic        m_szok;
  logic [2:0]  m_sel;
  logic [31:0] m_old, m_rd, m_new;

  function automatic logic [31:0] mdl_merge(
    input logic [31:0] old, input logic [31:0] d,
    input logic [1:0] a, input logic [2:0] sz);
    logic [3:0]  be;
    logic [31:0] src, res;
    be  = 4'h0;
    src = d;
    if (sz == 3'd4) be = 4'hF;
    else if (sz == 3'd2) begin
      be  = a[1] ? 4'hC : 4'h3;
      src = {2{d[15:0]}};
    end else if (sz == 3'd1) begin
      be  = 4'b0001 << a;
      src = {4{d[7:0]}};
    end
    for (int i = 0; i < 4; i++)
      res[8*i +: 8] = be[i] ? src[8*i +: 8] : old[8*i +: 8];
    return res;
  endfunction

  assign m_now  = m_base + m_cyc / 64'(P);
  assign m_acc  = bus.wb_cyc & bus.wb_stb & !m_busy;
  assign m_sel  = bus.wb_addr[4:2];
  assign m_szok = bus.data_write_size inside {3'd1, 3'd2, 3'd4};

  always_comb begin
    m_old = 32'h0;
    m_rd  = 32'h0;
    case (m_sel)
      3'd0: begin m_old = {30'h0, m_led}; m_rd = m_old; end
      3'd1: begin m_old = m_now[31:0]; m_rd = m_old; end
      3'd2: begin m_old = m_now[63:32]; m_rd = m_shadow; end
      3'd3: begin m_old = m_cmp[31:0]; m_rd = m_old; end
      3'd4: begin m_old = m_cmp[63:32]; m_rd = m_old; end
      3'd5: begin
        m_old = {29'h0, m_pend, m_ien, m_cen};
        m_rd  = m_old;
      end
      default: begin m_old = 32'h0; m_rd = 32'h0; end
    endcase
  end

  assign m_new = mdl_merge(m_old, bus.wb_data_in,
                           bus.wb_addr[1:0], bus.data_write_size);

  always @(posedge clk) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_rdata  <= '0;
      m_led    <= '0;
      m_base   <= '0;
      m_cyc    <= '0;
      m_cmp    <= '1;
      m_shadow <= '0;
      m_cen    <= 1'b0;
      m_ien    <= 1'b0;
      m_pend   <= 1'b0;
      m_irq    <= 1'b0;
    end else begin
      m_busy <= m_acc;
      m_pend <= (m_now >= m_cmp);
      m_irq  <= m_pend & m_ien;
      if (m_cen) m_cyc <= m_cyc + 64'd1;
      if (m_acc && !bus.wb_we) begin
        m_rdata <= m_rd;
        if (m_sel == 3'd1) m_shadow <= m_now[63:32];
      end
      if (m_acc && bus.wb_we && m_szok) begin
        case (m_sel)
          3'd0: m_led <= m_new[1:0];
          3'd1: begin
            m_base <= {m_now[63:32], m_new};
            m_cyc  <= '0;
          end
          3'd2: begin
            m_base <= {m_new, m_now[31:0]};
            m_cyc  <= '0;
          end
          3'd3: m_cmp[31:0]  <= m_new;
          3'd4: m_cmp[63:32] <= m_new;
          3'd5: begin
            m_cen <= m_new[0];
            m_ien <= m_new[1];
          end
          default: ;
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(bus.wb_ack), 32'(m_busy));
      chk("stall", 32'(bus.wb_stall), 32'(m_busy));
      chk("rdata", bus.wb_data_out, m_rdata);
      chk("led", 32'(led), 32'(m_led));
      chk("irq", 32'(timer_irq), 32'(m_irq));
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_bus();
    bus.wb_cyc          = 1'b0;
    bus.wb_stb          = 1'b0;
    bus.wb_we           = 1'b0;
    bus.wb_addr         = '0;
    bus.wb_data_in      = '0;
    bus.data_write_size = 3'd0;
  endtask

  task automatic bus_rw(input logic we,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [2:0] sz,
                        output logic [31:0] rd);
    logic seen;
    @(negedge clk);
    bus.wb_cyc          = 1'b1;
    bus.wb_stb          = 1'b1;
    bus.wb_we           = we;
    bus.wb_addr         = a;
    bus.wb_data_in      = d;
    bus.data_write_size = sz;
    @(posedge clk);
    @(negedge clk);
    idle_bus();
    seen = 1'b0;
    rd   = '0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (bus.wb_ack) begin
        seen = 1'b1;
        rd   = bus.wb_data_out;
      end else @(negedge clk);
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [2:0] sz);
    logic [31:0] dummy;
    bus_rw(1'b1, a, d, sz, dummy);
  endtask

  task automatic rd_chk(input string nm,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    bus_rw(1'b0, a, 32'h0, 3'd4, v);
    chk(nm, v, exp);
  endtask

  function automatic logic [2:0] pick_size();
    case ($urandom_range(0, 7))
      0, 1, 2: return 3'd4;
      3, 4:    return 3'd2;
      5, 6:    return 3'd1;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    logic [31:0] v;
    idle_bus();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // reset while counting, with live LED and CTRL state
    wr(32'h00, 32'h2, 3'd4);
    wr(32'h14, 32'h3, 3'd4);
    wr(32'h0C, 32'h0, 3'd4);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    chk("rst_ack", 32'(bus.wb_ack), 32'h0);
    chk("rst_stall", 32'(bus.wb_stall), 32'h0);
    chk("rst_dout", bus.wb_data_out, 32'h0);
    rd_chk("rst_cmp_lo", 32'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_cmp_hi", 32'h10, 32'hFFFF_FFFF);
    rd_chk("rst_ctrl", 32'h14, 32'h0);
    rd_chk("rst_mtime", 32'h04, 32'h0);

    // LED write/read
    wr(32'h00, 32'h3, 3'd4);
    chk("led_lit", 32'(led), 32'h3);
    rd_chk("led_rd", 32'h00, 32'h3);

    // count 81 enabled cycles -> 10 ticks, then freeze
    wr(32'h14, 32'h1, 3'd4);
    repeat (80) @(negedge clk);
    rd_chk("mtime_run", 32'h04, 32'd10);
    wr(32'h14, 32'h0, 3'd4);
    repeat (50) @(negedge clk);
    rd_chk("mtime_frz", 32'h04, 32'd10);

    // carry from LO into HI, shadowed HI read
    wr(32'h04, 32'hFFFF_FFFF, 3'd4);
    wr(32'h08, 32'h0, 3'd4);
    wr(32'h14, 32'h1, 3'd4);
    repeat (9) @(negedge clk);
    rd_chk("wrap_lo", 32'h04, 32'h0);
    rd_chk("wrap_hi", 32'h08, 32'h1);
    repeat (30) @(negedge clk);
    rd_chk("shadow_hi", 32'h08, 32'h1);
    wr(32'h14, 32'h0, 3'd4);

    // byte and halfword lanes
    wr(32'h0C, 32'h0, 3'd4);
    wr(32'h0D, 32'h5555_55AB, 3'd1);
    rd_chk("byte_ln", 32'h0C, 32'h0000_AB00);
    wr(32'h0E, 32'hCCCC_1234, 3'd2);
    rd_chk("half_ln", 32'h0C, 32'h1234_AB00);
    wr(32'h0C, 32'h0, 3'd3);
    rd_chk("bad_size", 32'h0C, 32'h1234_AB00);

    // interrupt rise and clear
    wr(32'h04, 32'h0, 3'd4);
    wr(32'h08, 32'h0, 3'd4);
    wr(32'h10, 32'h0, 3'd4);
    wr(32'h0C, 32'h5, 3'd4);
    wr(32'h14, 32'h3, 3'd4);
    chk("irq_low", 32'(timer_irq), 32'h0);
    repeat (60) @(negedge clk);
    chk("irq_high", 32'(timer_irq), 32'h1);
    rd_chk("ctrl_pend", 32'h14, 32'h7);
    wr(32'h10, 32'h1, 3'd4);
    repeat (2) @(negedge clk);
    chk("irq_clr", 32'(timer_irq), 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        @(negedge clk);
        bus.wb_cyc     = 1'b1;
        bus.wb_stb     = 1'b1;
        bus.wb_we      = 1'($urandom);
        bus.wb_addr    = 32'($urandom_range(0, 31));
        bus.wb_data_in = $urandom;
        bus.data_write_size = pick_size();
        @(negedge clk);
        idle_bus();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
      end else if (r < 8) begin
        @(negedge clk);
        bus.wb_stb     = 1'b1;
        bus.wb_we      = 1'b1;
        bus.wb_addr    = 32'($urandom_range(0, 31));
        bus.wb_data_in = $urandom;
        bus.data_write_size = 3'd4;
        @(negedge clk);
        idle_bus();
      end else if (r < 15) begin
        repeat ($urandom_range(1, 5)) @(negedge clk);
      end else begin
        logic [31:0] a;
        logic [31:0] d;
        a = 32'($urandom_range(0, 31));
        d = $urandom;
        if (r < 20) d = 32'($urandom_range(0, 3));
        bus_rw(1'($urandom), a, d, pick_size(), v);
      end
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
